ravenoc_edge_sink: RTL

RAVENOC_EDGE_SINK -- requirements
Module: ravenoc_edge_sink

---
 rtl/ravenoc_edge_sink.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ravenoc_edge_sink.sv
// ravenoc_edge_sink: mesh-boundary port terminator with per-VC packet
// tracking, saturating flit/packet counters and sticky error capture.
// Optional error interrupt pulse enabled with `define RAVENOC_EDGE_IRQ_EN.
module ravenoc_edge_sink #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 3,
    parameter int CNT_WIDTH  = 16,
    parameter int SINK_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [FLIT_WIDTH-1:0] flit_data_i,
    input  logic [N_VIRT_CHN-1:0] valid_i,
    output logic [N_VIRT_CHN-1:0] ready_o,
    input  logic                  clear_i,
    output logic [CNT_WIDTH-1:0]  flit_cnt_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic                  err_o,
    output logic [$clog2(N_VIRT_CHN > 2 ? N_VIRT_CHN : 2)-1:0] err_vc_o,
    output logic                  irq_o
);

    localparam int VC_W = $clog2(N_VIRT_CHN > 2 ? N_VIRT_CHN : 2);

    typedef enum logic [1:0] {
        FT_HEAD = 2'b00,
        FT_BODY = 2'b01,
        FT_TAIL = 2'b10,
        FT_HT   = 2'b11
    } flit_type_t;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } vc_state_t;

    flit_type_t            ftype;
    logic                  unused_payload;
    logic [N_VIRT_CHN-1:0] ready_q;
    logic [N_VIRT_CHN-1:0] accept;
    logic [N_VIRT_CHN-1:0] vc_err;
    logic [N_VIRT_CHN-1:0] vc_done;
    logic                  multi;
    logic                  err_any;
    logic                  pkt_any;
    logic [VC_W-1:0]       low_vc;
    logic [CNT_WIDTH-1:0]  flit_q;
    logic [CNT_WIDTH-1:0]  pkt_q;
    logic                  err_q;
    logic [VC_W-1:0]       err_vc_q;

    assign ftype          = flit_type_t'(flit_data_i[FLIT_WIDTH-1 -: 2]);
    assign unused_payload = ^flit_data_i[FLIT_WIDTH-3:0];

    // Ready comes up one edge after reset releases; blocking mode never raises it
    always_ff @(posedge clk) begin
        if (arst) begin
            ready_q <= '0;
        end else begin
            ready_q <= {N_VIRT_CHN{SINK_MODE != 0}};
        end
    end

    assign ready_o = ready_q;
    assign accept  = valid_i & ready_q;
    assign multi   = $countones(accept) > 1;

    for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
        vc_state_t state_q;
        logic      in_pkt;
        logic      is_open;
        logic      is_cont;

        assign in_pkt  = (state_q == ST_IN_PKT);
        assign is_open = (ftype == FT_HEAD) || (ftype == FT_HT);
        assign is_cont = (ftype == FT_BODY) || (ftype == FT_TAIL);

        assign vc_err[v]  = accept[v] & (in_pkt ? is_open : is_cont);
        assign vc_done[v] = accept[v] &
                            (in_pkt ? (ftype == FT_TAIL) : (ftype == FT_HT));

        // Packet framing state: a head opens, tail/head-tail close, body keeps
        always_ff @(posedge clk) begin
            if (arst) begin
                state_q <= ST_IDLE;
            end else if (accept[v]) begin
                unique case (ftype)
                    FT_HEAD: state_q <= ST_IN_PKT;
                    FT_BODY: state_q <= state_q;
                    FT_TAIL: state_q <= ST_IDLE;
                    FT_HT:   state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign err_any = (|vc_err) | multi;
    assign pkt_any = |vc_done;

    // Lowest accepted VC is the one reported for an error in this cycle
    always_comb begin
        low_vc = '0;
        for (int i = N_VIRT_CHN - 1; i >= 0; i--) begin
            if (accept[i]) begin
                low_vc = VC_W'(i);
            end
        end
    end

    // Accepted-flit counter, one count per accepting cycle, saturating
    always_ff @(posedge clk) begin
        if (arst || clear_i) begin
            flit_q <= '0;
        end else if ((|accept) && (flit_q != '1)) begin
            flit_q <= flit_q + CNT_WIDTH'(1);
        end
    end

    // Completed-packet counter, saturating
    always_ff @(posedge clk) begin
        if (arst || clear_i) begin
            pkt_q <= '0;
        end else if (pkt_any && (pkt_q != '1)) begin
            pkt_q <= pkt_q + CNT_WIDTH'(1);
        end
    end

    // Sticky error flag; the VC is latched only by the error that sets it
    always_ff @(posedge clk) begin
        if (arst || clear_i) begin
            err_q    <= 1'b0;
            err_vc_q <= '0;
        end else if (err_any && !err_q) begin
            err_q    <= 1'b1;
            err_vc_q <= low_vc;
        end
    end

    assign flit_cnt_o = flit_q;
    assign pkt_cnt_o  = pkt_q;
    assign err_o      = err_q;
    assign err_vc_o   = err_vc_q;

`ifdef RAVENOC_EDGE_IRQ_EN
    logic irq_q;

    // One-cycle pulse aligned with the rising edge of the sticky flag
    always_ff @(posedge clk) begin
        if (arst || clear_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= err_any && !err_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule
